// File: rtl/xgriscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: ALU op codes,
// FSM states, opcodes and datapath select values.
package xgriscv_ctrl_pkg;

  localparam int unsigned ALUOP_W = 4;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_GE   = 4'd10;
  localparam logic [3:0] ALU_GEU  = 4'd11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_MEMADDR = 4'd4,
    S_MEMRD   = 4'd5,
    S_MEMWR   = 4'd6,
    S_WB_ALU  = 4'd7,
    S_WB_MEM  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_JALR    = 4'd11,
    S_LUI     = 4'd12,
    S_AUIPC   = 4'd13,
    S_TRAP    = 4'd14
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] ASEL_RS1   = 2'd0;
  localparam logic [1:0] ASEL_PC    = 2'd1;
  localparam logic [1:0] ASEL_OLDPC = 2'd2;
  localparam logic [1:0] ASEL_ZERO  = 2'd3;

  localparam logic [1:0] BSEL_RS2  = 2'd0;
  localparam logic [1:0] BSEL_IMM  = 2'd1;
  localparam logic [1:0] BSEL_FOUR = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // BEQ compares with SUB and is taken on equality; all other branches use
  // an ALU op whose result is nonzero exactly when the branch is taken.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    return (funct3 == 3'b000) ? zero : ~zero;
  endfunction

endpackage

// File: rtl/xgriscv_aluop_dec.sv
// Combinational ALU operation decode from opcode, funct3 and funct7[5]
// for register-register, register-immediate and branch instructions.
module xgriscv_aluop_dec
  import xgriscv_ctrl_pkg::*;
(
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  output logic [ALUOP_W-1:0] alu_op
);

  // funct7[5] selects SUB only for register-register ops; SRA/SRAI honour it for both
  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OPC_OP, OPC_OPIMM: begin
        case (funct3)
          3'b000: begin
            if ((opcode == OPC_OP) && funct7_5) alu_op = ALU_SUB;
            else                                alu_op = ALU_ADD;
          end
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: begin
            if (funct7_5) alu_op = ALU_SRA;
            else          alu_op = ALU_SRL;
          end
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: alu_op = ALU_SUB;
          3'b100:         alu_op = ALU_SLT;
          3'b101:         alu_op = ALU_GE;
          3'b110:         alu_op = ALU_SLTU;
          3'b111:         alu_op = ALU_GEU;
          default:        alu_op = ALU_SUB;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/xgriscv_mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives ALU op, operand selects and datapath enables.
module xgriscv_mc_ctrl
  import xgriscv_ctrl_pkg::*;
#(
  parameter logic [3:0]  RESET_STATE = 4'd0,
  parameter int unsigned ALUOP_W     = xgriscv_ctrl_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [31:0]        instr,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         alu_a_sel,
  output logic [1:0]         alu_b_sel,
  output logic [2:0]         imm_type,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               ir_we,
  output logic               pc_we,
  output logic               oldpc_we,
  output logic               tgt_we,
  output logic               aluout_we,
  output logic               rf_we,
  output logic               pc_src,
  output logic [1:0]         wb_sel,
  output logic               illegal
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic       funct7_5_s;
  logic       unused_instr_s;

  assign opcode_s       = instr[6:0];
  assign funct3_s       = instr[14:12];
  assign funct7_5_s     = instr[30];
  assign unused_instr_s = ^{instr[31], instr[29:15], instr[11:7]};

  logic [ALUOP_W-1:0] dec_op_s;

  xgriscv_aluop_dec u_aluop_dec (
    .opcode   (opcode_s),
    .funct3   (funct3_s),
    .funct7_5 (funct7_5_s),
    .alu_op   (dec_op_s)
  );

  // State and sticky illegal-instruction flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= state_e'(RESET_STATE);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic; unused encodings fall into TRAP
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) state_d = S_DECODE;
        else            state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode_s)
          OPC_OP:               state_d = S_EXEC_R;
          OPC_OPIMM:            state_d = S_EXEC_I;
          OPC_LOAD, OPC_STORE:  state_d = S_MEMADDR;
          OPC_BRANCH:           state_d = S_BRANCH;
          OPC_JAL:              state_d = S_JAL;
          OPC_JALR:             state_d = S_JALR;
          OPC_LUI:              state_d = S_LUI;
          OPC_AUIPC:            state_d = S_AUIPC;
          default:              state_d = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_d = S_WB_ALU;
      S_MEMADDR: begin
        if (opcode_s == OPC_STORE) state_d = S_MEMWR;
        else                       state_d = S_MEMRD;
      end
      S_MEMRD: begin
        if (dmem_ready) state_d = S_WB_MEM;
        else            state_d = S_MEMRD;
      end
      S_MEMWR: begin
        if (dmem_ready) state_d = S_FETCH;
        else            state_d = S_MEMWR;
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  logic [ALUOP_W-1:0] alu_op_s;
  logic [1:0]         a_sel_s, b_sel_s, wb_sel_s;
  logic [2:0]         imm_type_s;
  logic               imem_req_s, dmem_req_s, dmem_we_s;
  logic               ir_we_s, pc_we_s, oldpc_we_s, tgt_we_s, aluout_we_s, rf_we_s;
  logic               pc_src_s;

  // Moore output decode; only the FETCH enables look at imem_ready
  always_comb begin
    alu_op_s    = ALU_ADD;
    a_sel_s     = ASEL_RS1;
    b_sel_s     = BSEL_RS2;
    imm_type_s  = IMM_I;
    wb_sel_s    = WB_ALUOUT;
    imem_req_s  = 1'b0;
    dmem_req_s  = 1'b0;
    dmem_we_s   = 1'b0;
    ir_we_s     = 1'b0;
    pc_we_s     = 1'b0;
    oldpc_we_s  = 1'b0;
    tgt_we_s    = 1'b0;
    aluout_we_s = 1'b0;
    rf_we_s     = 1'b0;
    pc_src_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_s = 1'b1;
        a_sel_s    = ASEL_PC;
        b_sel_s    = BSEL_FOUR;
        if (imem_ready) begin
          ir_we_s    = 1'b1;
          oldpc_we_s = 1'b1;
          pc_we_s    = 1'b1;
        end else begin
          ir_we_s    = 1'b0;
          oldpc_we_s = 1'b0;
          pc_we_s    = 1'b0;
        end
      end
      S_DECODE: begin
        a_sel_s    = ASEL_OLDPC;
        b_sel_s    = BSEL_IMM;
        imm_type_s = (opcode_s == OPC_JAL) ? IMM_J : IMM_B;
        tgt_we_s   = 1'b1;
      end
      S_EXEC_R: begin
        alu_op_s    = dec_op_s;
        aluout_we_s = 1'b1;
      end
      S_EXEC_I: begin
        alu_op_s    = dec_op_s;
        b_sel_s     = BSEL_IMM;
        aluout_we_s = 1'b1;
      end
      S_MEMADDR: begin
        b_sel_s     = BSEL_IMM;
        imm_type_s  = (opcode_s == OPC_STORE) ? IMM_S : IMM_I;
        aluout_we_s = 1'b1;
      end
      S_MEMRD: dmem_req_s = 1'b1;
      S_MEMWR: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = 1'b1;
      end
      S_WB_ALU: rf_we_s = 1'b1;
      S_WB_MEM: begin
        rf_we_s  = 1'b1;
        wb_sel_s = WB_MDR;
      end
      S_BRANCH: begin
        alu_op_s   = dec_op_s;
        imm_type_s = IMM_B;
        if (branch_taken(funct3_s, zero)) begin
          pc_we_s  = 1'b1;
          pc_src_s = 1'b1;
        end else begin
          pc_we_s  = 1'b0;
          pc_src_s = 1'b0;
        end
      end
      S_JAL: begin
        imm_type_s = IMM_J;
        rf_we_s    = 1'b1;
        wb_sel_s   = WB_PC;
        pc_we_s    = 1'b1;
        pc_src_s   = 1'b1;
      end
      S_JALR: begin
        b_sel_s  = BSEL_IMM;
        rf_we_s  = 1'b1;
        wb_sel_s = WB_PC;
        pc_we_s  = 1'b1;
      end
      S_LUI: begin
        a_sel_s     = ASEL_ZERO;
        b_sel_s     = BSEL_IMM;
        imm_type_s  = IMM_U;
        aluout_we_s = 1'b1;
      end
      S_AUIPC: begin
        a_sel_s     = ASEL_OLDPC;
        b_sel_s     = BSEL_IMM;
        imm_type_s  = IMM_U;
        aluout_we_s = 1'b1;
      end
      S_TRAP:  imem_req_s = 1'b0;
      default: imem_req_s = 1'b0;
    endcase
  end

  // Reset forces every output inactive at once, so an open request drops
  // without waiting for a clock edge.
  assign alu_op    = rstn ? alu_op_s   : ALU_ADD;
  assign alu_a_sel = rstn ? a_sel_s    : ASEL_RS1;
  assign alu_b_sel = rstn ? b_sel_s    : BSEL_RS2;
  assign imm_type  = rstn ? imm_type_s : IMM_I;
  assign wb_sel    = rstn ? wb_sel_s   : WB_ALUOUT;
  assign imem_req  = rstn & imem_req_s;
  assign dmem_req  = rstn & dmem_req_s;
  assign dmem_we   = rstn & dmem_we_s;
  assign ir_we     = rstn & ir_we_s;
  assign pc_we     = rstn & pc_we_s;
  assign oldpc_we  = rstn & oldpc_we_s;
  assign tgt_we    = rstn & tgt_we_s;
  assign aluout_we = rstn & aluout_we_s;
  assign rf_we     = rstn & rf_we_s;
  assign pc_src    = rstn & pc_src_s;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_xgriscv_mc_ctrl.sv
// Directed self-checking bench for xgriscv_mc_ctrl: walks each instruction
// class through its states and checks the decoded controls cycle by cycle.
module tb_xgriscv_mc_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] instr;
  logic        zero, imem_ready, dmem_ready;
  logic [3:0]  alu_op;
  logic [1:0]  alu_a_sel, alu_b_sel, wb_sel;
  logic [2:0]  imm_type;
  logic        imem_req, dmem_req, dmem_we;
  logic        ir_we, pc_we, oldpc_we, tgt_we, aluout_we, rf_we, pc_src, illegal;

  int n_total = 0;
  int n_bad   = 0;

  // {imem_req, dmem_req, dmem_we, ir_we, pc_we, oldpc_we, tgt_we, aluout_we, rf_we}
  logic [8:0] en;
  assign en = {imem_req, dmem_req, dmem_we, ir_we, pc_we, oldpc_we, tgt_we, aluout_we, rf_we};

  localparam logic [8:0] EN_NONE   = 9'h000;
  localparam logic [8:0] EN_FWAIT  = 9'h100;
  localparam logic [8:0] EN_FETCH  = 9'h138;
  localparam logic [8:0] EN_DECODE = 9'h004;
  localparam logic [8:0] EN_EXEC   = 9'h002;
  localparam logic [8:0] EN_WB     = 9'h001;
  localparam logic [8:0] EN_MEMRD  = 9'h080;
  localparam logic [8:0] EN_MEMWR  = 9'h0C0;
  localparam logic [8:0] EN_BR     = 9'h010;
  localparam logic [8:0] EN_JUMP   = 9'h011;

  xgriscv_mc_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .instr      (instr),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .alu_op     (alu_op),
    .alu_a_sel  (alu_a_sel),
    .alu_b_sel  (alu_b_sel),
    .imm_type   (imm_type),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .oldpc_we   (oldpc_we),
    .tgt_we     (tgt_we),
    .aluout_we  (aluout_we),
    .rf_we      (rf_we),
    .pc_src     (pc_src),
    .wb_sel     (wb_sel),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // From FETCH (imem_ready low): fetch w with ready on the first cycle,
  // check FETCH and DECODE, and return positioned in the following state.
  task automatic fetch_decode(input string tag, input logic [31:0] w);
    logic [2:0] exp_imm;
    #1;
    chk({tag, ":fetch_wait_en"}, 32'(en), 32'(EN_FWAIT));
    imem_ready = 1'b1;
    instr      = w;
    #1;
    chk({tag, ":fetch_en"}, 32'(en), 32'(EN_FETCH));
    chk({tag, ":fetch_sel"}, 32'({alu_a_sel, alu_b_sel, alu_op, pc_src}), 32'({2'd1, 2'd2, 4'd0, 1'b0}));
    cyc();
    imem_ready = 1'b0;
    exp_imm = (w[6:0] == 7'b1101111) ? 3'd4 : 3'd2;
    #1;
    chk({tag, ":dec_en"}, 32'(en), 32'(EN_DECODE));
    chk({tag, ":dec_sel"}, 32'({alu_a_sel, alu_b_sel, alu_op, imm_type}), 32'({2'd2, 2'd1, 4'd0, exp_imm}));
    cyc();
  endtask

  // Execute-then-WB_ALU sequence (R/I/LUI/AUIPC).
  task automatic exec_wb(input string tag, input logic [3:0] op, input logic [1:0] a, input logic [1:0] b);
    #1;
    chk({tag, ":exec_en"}, 32'(en), 32'(EN_EXEC));
    chk({tag, ":exec_sel"}, 32'({alu_a_sel, alu_b_sel, alu_op}), 32'({a, b, op}));
    cyc();
    #1;
    chk({tag, ":wb_en"}, 32'(en), 32'(EN_WB));
    chk({tag, ":wb_sel"}, 32'(wb_sel), 32'd0);
    cyc();
  endtask

  task automatic branch(input string tag, input logic [31:0] w, input logic z, input logic [3:0] op, input logic taken);
    fetch_decode(tag, w);
    zero = z;
    #1;
    chk({tag, ":br_op"}, 32'({alu_a_sel, alu_b_sel, alu_op}), 32'({2'd0, 2'd0, op}));
    chk({tag, ":br_en"}, 32'(en), taken ? 32'(EN_BR) : 32'(EN_NONE));
    if (taken) chk({tag, ":br_src"}, 32'(pc_src), 32'd1);
    cyc();
    zero = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; instr = 32'd0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #3;
    chk("rst_en", 32'(en), 32'(EN_NONE));
    chk("rst_sel", 32'({alu_a_sel, alu_b_sel, alu_op, imm_type, wb_sel, pc_src}), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // ADD x3,x1,x2: rf_we in the 4th cycle counting the first imem_req cycle
    fetch_decode("add", 32'h002081B3);
    exec_wb("add", 4'd0, 2'd0, 2'd0);
    fetch_decode("sub", 32'h402081B3);
    exec_wb("sub", 4'd1, 2'd0, 2'd0);

    // SRAI x5,x5,3
    fetch_decode("srai", 32'h4032D293);
    #1;
    chk("srai:imm", 32'(imm_type), 32'd0);
    exec_wb("srai", 4'd7, 2'd0, 2'd1);
    // ADDI x1,x0,0x400 (instr[30] set)
    fetch_decode("addi", 32'h40000093);
    exec_wb("addi", 4'd0, 2'd0, 2'd1);

    branch("blt_nz", 32'h0020C063, 1'b0, 4'd8, 1'b1);
    branch("blt_z",  32'h0020C063, 1'b1, 4'd8, 1'b0);
    branch("beq_z",  32'h00208063, 1'b1, 4'd1, 1'b1);
    branch("bne_z",  32'h00209063, 1'b1, 4'd1, 1'b0);
    branch("bgeu",   32'h0020F063, 1'b0, 4'd11, 1'b1);

    // LW x5,0(x1) with one wait cycle
    fetch_decode("lw", 32'h0000A283);
    #1;
    chk("lw:addr_en", 32'(en), 32'(EN_EXEC));
    chk("lw:addr_sel", 32'({alu_a_sel, alu_b_sel, alu_op, imm_type}), 32'({2'd0, 2'd1, 4'd0, 3'd0}));
    cyc();
    #1;
    chk("lw:rd0_en", 32'(en), 32'(EN_MEMRD));
    cyc();
    dmem_ready = 1'b1;
    #1;
    chk("lw:rd1_en", 32'(en), 32'(EN_MEMRD));
    cyc();
    dmem_ready = 1'b0;
    #1;
    chk("lw:wb_en", 32'(en), 32'(EN_WB));
    chk("lw:wb_sel", 32'(wb_sel), 32'd1);
    cyc();

    // SW x2,0(x1) with dmem_ready low for 3 cycles
    fetch_decode("sw", 32'h0020A023);
    #1;
    chk("sw:addr_imm", 32'(imm_type), 32'd1);
    chk("sw:addr_en", 32'(en), 32'(EN_EXEC));
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("sw:wait%0d_en", i), 32'(en), 32'(EN_MEMWR));
      cyc();
    end
    dmem_ready = 1'b1;
    #1;
    chk("sw:ready_en", 32'(en), 32'(EN_MEMWR));
    cyc();
    dmem_ready = 1'b0;

    // JAL x1,0
    fetch_decode("jal", 32'h000000EF);
    #1;
    chk("jal:en", 32'(en), 32'(EN_JUMP));
    chk("jal:ctl", 32'({wb_sel, pc_src}), 32'({2'd2, 1'b1}));
    cyc();

    // JALR x1,0(x1)
    fetch_decode("jalr", 32'h000080E7);
    #1;
    chk("jalr:en", 32'(en), 32'(EN_JUMP));
    chk("jalr:ctl", 32'({wb_sel, pc_src, alu_a_sel, alu_b_sel, alu_op, imm_type}),
        32'({2'd2, 1'b0, 2'd0, 2'd1, 4'd0, 3'd0}));
    cyc();

    fetch_decode("lui", 32'h123450B7);
    #1;
    chk("lui:imm", 32'(imm_type), 32'd3);
    exec_wb("lui", 4'd0, 2'd3, 2'd1);
    fetch_decode("auipc", 32'h00000097);
    #1;
    chk("auipc:imm", 32'(imm_type), 32'd3);
    exec_wb("auipc", 4'd0, 2'd2, 2'd1);

    // Reset in MEMRD with dmem_ready never asserted
    fetch_decode("lwrst", 32'h0000A283);
    cyc();
    #1;
    chk("lwrst:rd_en", 32'(en), 32'(EN_MEMRD));
    cyc();
    #1;
    chk("lwrst:rd2_en", 32'(en), 32'(EN_MEMRD));
    rstn = 1'b0;
    #1;
    chk("lwrst:drop_en", 32'(en), 32'(EN_NONE));
    @(negedge clk);
    rstn = 1'b1;

    // Undecodable opcode 0x7F
    fetch_decode("ill", 32'h0000007F);
    #1;
    chk("ill:flag", 32'(illegal), 32'd1);
    chk("ill:en", 32'(en), 32'(EN_NONE));
    imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      chk($sformatf("ill:hold%0d", i), 32'({illegal, en}), 32'({1'b1, EN_NONE}));
    end
    rstn = 1'b0;
    #1;
    chk("ill:rst", 32'(illegal), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
